// File: rtl/systolic_skew_feeder_if.sv
// Interface bundling the pass control, input beat handshake and skewed array-edge outputs
// of the systolic skew feeder. The feeder uses the slave modport, its controller the master.
interface systolic_skew_feeder_if #(
    parameter int bit_res        = 32,
    parameter int lanes          = 4,
    parameter int index_bit_size = 16
);
    logic                       start;
    logic [index_bit_size-1:0]  k_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [lanes*bit_res-1:0]   in_data;
    logic                       array_clr;
    logic [lanes*bit_res-1:0]   lane_out;
    logic [lanes-1:0]           lane_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, array_clr, lane_out, lane_valid, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, array_clr, lane_out, lane_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Producer end of a systolic MAC array edge: accepts one lanes-wide vector per beat and
// emits it diagonally skewed (lane i delayed by i extra cycles), zero-filling bubbles and
// flushing with zero slots so every array cell finishes accumulating before done.
module systolic_skew_feeder #(
    parameter int bit_res        = 32,
    parameter int lanes          = 4,
    parameter int index_bit_size = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_skew_feeder_if.slave bus
);
    localparam int CNT_W = (lanes > 2) ? $clog2(lanes) : 1;
    localparam logic [CNT_W-1:0]          FLUSH_LAST = CNT_W'(lanes - 2);
    localparam logic [index_bit_size-1:0] ONE        = index_bit_size'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        FLUSH,
        FIN
    } state_t;

    state_t                    state;
    logic [index_bit_size-1:0] k_len_q;
    logic [index_bit_size-1:0] beat_cnt;
    logic [CNT_W-1:0]          flush_cnt;
    logic                      in_ready_q;
    logic                      clr_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      accept;

    logic [bit_res-1:0]        tail_data [lanes];
    logic                      tail_valid [lanes];
    logic [lanes*bit_res-1:0]  lane_out_c;
    logic [lanes-1:0]          lane_valid_c;

    // A slot carries real data only when a beat is offered while streaming; otherwise it is zero.
    assign accept = (state == STREAM) && bus.in_valid;

    // Pass sequencing; every control output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            k_len_q    <= '0;
            beat_cnt   <= '0;
            flush_cnt  <= '0;
            in_ready_q <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.k_len != '0) begin
                            k_len_q  <= bus.k_len;
                            beat_cnt <= '0;
                            clr_q    <= 1'b1;
                            state    <= CLR;
                        end else begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                CLR: begin
                    clr_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= STREAM;
                end
                STREAM: begin
                    if (bus.in_valid) begin
                        beat_cnt <= beat_cnt + ONE;
                        if (beat_cnt == k_len_q - ONE) begin
                            in_ready_q <= 1'b0;
                            flush_cnt  <= '0;
                            state      <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    clr_q      <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic [bit_res-1:0] pipe_data  [0:i];
        logic               pipe_valid [0:i];

        // Lane i is a chain of i+1 registers that shifts every cycle, so bubbles keep the skew.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    pipe_data[s]  <= '0;
                    pipe_valid[s] <= 1'b0;
                end
            end else begin
                pipe_data[0]  <= accept ? bus.in_data[i*bit_res +: bit_res] : '0;
                pipe_valid[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    pipe_data[s]  <= pipe_data[s-1];
                    pipe_valid[s] <= pipe_valid[s-1];
                end
            end
        end

        assign tail_data[i]  = pipe_data[i];
        assign tail_valid[i] = pipe_valid[i];
    end

    // Gather the last stage of each lane chain into the packed array-edge buses.
    always_comb begin
        lane_out_c   = '0;
        lane_valid_c = '0;
        for (int i = 0; i < lanes; i++) begin
            lane_out_c[i*bit_res +: bit_res] = tail_data[i];
            lane_valid_c[i]                  = tail_valid[i];
        end
    end

    assign bus.lane_out   = lane_out_c;
    assign bus.lane_valid = lane_valid_c;
    assign bus.in_ready   = in_ready_q;
    assign bus.array_clr  = clr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for the systolic skew feeder (lanes=4, 32-bit elements) with hand-computed
// expected lane contents, handshake and pass-control outputs after every clock edge.
module tb_systolic_skew_feeder;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    systolic_skew_feeder_if #(.bit_res(32), .lanes(4), .index_bit_size(16)) bus ();

    systolic_skew_feeder #(.bit_res(32), .lanes(4), .index_bit_size(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Pack four elements with element 0 in the low bits, as lane 0 sees it.
    function automatic logic [127:0] beat(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge that consumes them.
    task automatic applyStimulus(input bit st, input int kl, input bit iv, input logic [127:0] d);
        bus.start    = st;
        bus.k_len    = kl[15:0];
        bus.in_valid = iv;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expectAll(input string tag, input logic [127:0] lane, input logic [3:0] vld,
                             input bit rdy, input bit clr, input bit bsy, input bit dn);
        checkOutput({tag, ".lane_out"},   bus.lane_out,            lane);
        checkOutput({tag, ".lane_valid"}, 128'(bus.lane_valid),    128'(vld));
        checkOutput({tag, ".in_ready"},   128'(bus.in_ready),      128'(rdy));
        checkOutput({tag, ".array_clr"},  128'(bus.array_clr),     128'(clr));
        checkOutput({tag, ".busy"},       128'(bus.busy),          128'(bsy));
        checkOutput({tag, ".done"},       128'(bus.done),          128'(dn));
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        expectAll("reset", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] T1 back-to-back beats, k_len=3");
        applyStimulus(1'b1, 3, 1'b0, '0);
        expectAll("t1_clr",  '0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t1_strm", '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(1, 2, 3, 4));
        expectAll("t1_b1", beat(1, 0, 0, 0),   4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(5, 6, 7, 8));
        expectAll("t1_b2", beat(5, 2, 0, 0),   4'b0011, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(9, 10, 11, 12));
        expectAll("t1_b3", beat(9, 6, 3, 0),   4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t1_f1", beat(0, 10, 7, 4), 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t1_f2", beat(0, 0, 11, 8), 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t1_fin", beat(0, 0, 0, 12), 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t1_idle", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] T2 bubble between beats, k_len=2");
        applyStimulus(1'b1, 2, 1'b0, '0);
        expectAll("t2_clr",  '0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t2_strm", '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(21, 22, 23, 24));
        expectAll("t2_a",   beat(21, 0, 0, 0),  4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, beat(99, 99, 99, 99));
        expectAll("t2_gap", beat(0, 22, 0, 0),  4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(31, 32, 33, 34));
        expectAll("t2_b",   beat(31, 0, 23, 0), 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(77, 77, 77, 77));
        expectAll("t2_f1",  beat(0, 32, 0, 24), 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t2_f2",  beat(0, 0, 33, 0),  4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t2_fin", beat(0, 0, 0, 34),  4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t2_idle", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] T3 empty pass, k_len=0");
        applyStimulus(1'b1, 0, 1'b0, '0);
        expectAll("t3_fin",  '0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t3_idle", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] T4 reset mid-stream, then a clean k_len=1 pass");
        applyStimulus(1'b1, 5, 1'b0, '0);
        expectAll("t4_clr",  '0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_strm", '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(7, 8, 9, 10));
        expectAll("t4_b1", beat(7, 0, 0, 0), 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expectAll("t4_async", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1, 1'b0, '0);
        expectAll("t4_clr2",  '0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_strm2", '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, beat(32'hFF000000, 32'h00800000, 3, 4));
        expectAll("t4_neg", beat(32'hFF000000, 0, 0, 0), 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_f1",  beat(0, 32'h00800000, 0, 0), 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_f2",  beat(0, 0, 3, 0), 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_fin", beat(0, 0, 0, 4), 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t4_idle", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] T6 start and k_len changes during a pass");
        applyStimulus(1'b1, 2, 1'b0, '0);
        expectAll("t6_clr",  '0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, '0);
        expectAll("t6_strm", '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1, 1'b1, beat(41, 42, 43, 44));
        expectAll("t6_b1", beat(41, 0, 0, 0),  4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1, 1'b1, beat(51, 52, 53, 54));
        expectAll("t6_b2", beat(51, 42, 0, 0), 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, '0);
        expectAll("t6_f1", beat(0, 52, 43, 0), 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, '0);
        expectAll("t6_f2", beat(0, 0, 53, 44), 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, '0);
        expectAll("t6_fin", beat(0, 0, 0, 54), 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t6_idle",  '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, '0);
        expectAll("t6_quiet", '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
